if_id_stage: RTL
================

Name: if_id_stage

Overview:
- Consumer end of the instruction-fetch interface. Latches the fetched instruction and PC into the IF/ID pipeline register.
- Decodes J/JAL in ID and returns the jump redirect (Jump, ID_jpc) to fetch.
- Detects load-use hazards against EXE and drives the stall back to fetch.
- Squashes wrong-path instructions on taken branches from EXE and on jumps from ID.

Parameters:
- NOP_INST, 32'h0000_0000, instruction word inserted on flush and at reset.
- CNT_W, 32, width of the stall and flush performance counters.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- Reset  input  1  asynchronous, active-low reset.
- IF_Inst  input  32  instruction from fetch.
- IF_PC  input  32  address of IF_Inst.
- Branch  input  1  taken branch resolved in EXE; the instruction in ID is wrong-path.
- EXE_MemRead  input  1  the instruction in EXE is a load.
- EXE_Rt  input  5  destination register of the EXE load.
- ID_Inst  output  32  registered instruction for decode.
- ID_PC  output  32  registered PC for decode.
- ID_Valid  output  1  ID_Inst is a real instruction, not a bubble.
- Jump  output  1  redirect fetch to ID_jpc.
- ID_jpc  output  32  jump target.
- stall  output  1  hold fetch PC and the IF/ID register.
- stall_count  output  CNT_W  cycles with stall=1 since reset.
- flush_count  output  CNT_W  instructions squashed since reset.

Behaviour:
- Reset (Reset=0, asynchronous): ID_Inst=NOP_INST, ID_PC=0, ID_Valid=0, both counters=0. Jump, stall and ID_jpc follow combinationally: 0, 0, and {4'h0, 26'h0, 2'b00}.
- Decode fields from ID_Inst: op=[31:26], rs=[25:21], rt=[20:16], target=[25:0].
- rt is a source register when op is 000000 (R-type), 000100 (beq), 000101 (bne) or 101011 (sw).
- hazard (combinational) = ID_Valid & EXE_MemRead & (EXE_Rt != 0) & (EXE_Rt == rs | (EXE_Rt == rt & rt is a source)).
- stall = hazard & ~Branch.
- isJ = ID_Valid & (op == 000010 | op == 000011).
- Jump = isJ & ~stall & ~Branch.
- ID_jpc = {ID_PC_plus4[31:28], target, 2'b00}, where ID_PC_plus4 = ID_PC + 32'd4 with 32-bit wrap and carry discarded. ID_jpc is driven regardless of Jump.
- Register update priority on each rising edge:
  1. Branch: load NOP_INST, ID_Valid=0, keep ID_PC unchanged. flush_count += 1 if ID_Valid was 1.
  2. stall: hold ID_Inst, ID_PC and ID_Valid. stall_count += 1.
  3. Jump: load NOP_INST, ID_Valid=0, ID_PC=IF_PC. This squashes the delay-slot fetch. flush_count += 1.
  4. Otherwise: ID_Inst=IF_Inst, ID_PC=IF_PC, ID_Valid=1.
- Latency: one cycle from IF to ID. A load-use hazard inserts exactly one stall cycle, because EXE advances to a bubble on the next cycle. A jump costs one squashed slot.
- Simultaneous events:
  - Branch with a hazard: no stall; flush only.
  - Branch with a jump in ID: no Jump; flush only.
  - hazard with a jump in ID: stall first, then Jump on the following cycle.
- Counters saturate at all-ones; they do not wrap.
- Reset asserted mid-stall or mid-flush: all state returns immediately to reset values. The first instruction after reset release is captured normally.

Decomposition:
- Shared package holds:
  - opcode constants OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_SW, OP_LW;
  - NOP constant;
  - field-slice helper functions.
- One natural sub-module, hazard_detect: purely combinational, computes hazard from the ID fields, ID_Valid, EXE_MemRead and EXE_Rt. The IF/ID register, jump decode and counters stay in if_id_stage.

Test Plan:
- Reset then straight-line code: IF_PC=0x100, IF_Inst=0x00221820 (add) → next cycle ID_PC=0x100, ID_Inst=0x00221820, ID_Valid=1, Jump=0, stall=0.
- Jump: ID holds 0x08000040 at ID_PC=0x0040_0000 → Jump=1, ID_jpc=0x0000_0100. Next edge: ID_Inst=NOP, ID_Valid=0, flush_count=1.
- Load-use: EXE_MemRead=1, EXE_Rt=1, ID holds add rs=1 → stall=1 for one cycle and ID holds. With EXE_MemRead=0 the next cycle, the new instruction is captured; stall_count=1.
- Load-use case with EXE_Rt=0, or with rt not a source (e.g. lw rt=1 in ID) → stall=0.
- Branch=1 while the ID hazard and a J are both present → stall=0, Jump=0. Next edge: ID_Valid=0, ID_Inst=NOP, flush_count increments.
- Reset pulsed low mid-stall, asynchronously between edges → outputs go to reset values immediately, counters=0; normal capture resumes on the first edge after release.

Source files
------------

// File: rtl/if_id_stage_pkg.sv
//==============================================================================
// Module : if_id_stage_pkg
// Brief  : Opcode constants, NOP word and field decode helpers for the IF/ID stage
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

package if_id_stage_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_LW    = 6'b100011;

    localparam logic [31:0] NOP = 32'h0000_0000;

    typedef struct packed {
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [25:0] target;
    } id_fields_t;

    function automatic id_fields_t f_decode(input logic [31:0] inst);
        id_fields_t f;
        f.op     = inst[31:26];
        f.rs     = inst[25:21];
        f.rt     = inst[20:16];
        f.target = inst[25:0];
        return f;
    endfunction

    // rt is read (not written) by R-type ALU ops, branches and stores
    function automatic logic f_rt_is_src(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
    endfunction

    function automatic logic f_is_jump(input logic [5:0] op);
        return (op == OP_J) || (op == OP_JAL);
    endfunction

endpackage

`default_nettype wire

// File: rtl/if_id_stage_hazard_detect.sv
//==============================================================================
// Module : if_id_stage_hazard_detect
// Brief  : Combinational load-use hazard check of the ID instruction against EXE
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module if_id_stage_hazard_detect
    import if_id_stage_pkg::*;
(
    input  logic [5:0] i_op,
    input  logic [4:0] i_rs,
    input  logic [4:0] i_rt,
    input  logic       i_id_valid,
    input  logic       i_exe_memread,
    input  logic [4:0] i_exe_rt,
    output logic       o_hazard
);

    logic w_rs_match;
    logic w_rt_match;

    assign w_rs_match = (i_exe_rt == i_rs);
    assign w_rt_match = (i_exe_rt == i_rt) && f_rt_is_src(i_op);

    // r0 is hardwired zero, so a load targeting it never creates a dependency
    assign o_hazard = i_id_valid && i_exe_memread && (i_exe_rt != 5'd0)
                      && (w_rs_match || w_rt_match);

endmodule

`default_nettype wire

// File: rtl/if_id_stage.sv
//==============================================================================
// Module : if_id_stage
// Brief  : IF/ID pipeline register with jump redirect, load-use stall and flush
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module if_id_stage
    import if_id_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INST = NOP,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [31:0]      IF_Inst,
    input  logic [31:0]      IF_PC,
    input  logic             Branch,
    input  logic             EXE_MemRead,
    input  logic [4:0]       EXE_Rt,
    output logic [31:0]      ID_Inst,
    output logic [31:0]      ID_PC,
    output logic             ID_Valid,
    output logic             Jump,
    output logic [31:0]      ID_jpc,
    output logic             stall,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [31:0]      r_id_inst;
    logic [31:0]      r_id_pc;
    logic             r_id_valid;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    id_fields_t       w_f;
    logic             w_hazard;
    logic             w_stall;
    logic             w_jump;
    logic [3:0]       w_pc4_hi;
    logic [CNT_W-1:0] w_stall_inc;
    logic [CNT_W-1:0] w_flush_inc;

    assign w_f = f_decode(r_id_inst);

    if_id_stage_hazard_detect u_hazard_detect (
        .i_op          (w_f.op),
        .i_rs          (w_f.rs),
        .i_rt          (w_f.rt),
        .i_id_valid    (r_id_valid),
        .i_exe_memread (EXE_MemRead),
        .i_exe_rt      (EXE_Rt),
        .o_hazard      (w_hazard)
    );

    // A taken branch squashes ID anyway, so it overrides both stall and jump
    assign w_stall = w_hazard && !Branch;
    assign w_jump  = r_id_valid && f_is_jump(w_f.op) && !w_stall && !Branch;

    // Top nibble of PC+4: carry into bit 28 only when PC[27:2] is all ones
    assign w_pc4_hi = r_id_pc[31:28] + {3'b000, &r_id_pc[27:2]};

    assign w_stall_inc = (&r_stall_cnt) ? r_stall_cnt : r_stall_cnt + c_CNT_ONE;
    assign w_flush_inc = (&r_flush_cnt) ? r_flush_cnt : r_flush_cnt + c_CNT_ONE;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_id_inst   <= NOP_INST;
            r_id_pc     <= 32'd0;
            r_id_valid  <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (Branch) begin
            r_id_inst  <= NOP_INST;
            r_id_valid <= 1'b0;
            if (r_id_valid) begin
                r_flush_cnt <= w_flush_inc;
            end
        end else if (w_stall) begin
            r_stall_cnt <= w_stall_inc;
        end else if (w_jump) begin
            // The delay-slot fetch is discarded; its PC is kept for reference
            r_id_inst   <= NOP_INST;
            r_id_valid  <= 1'b0;
            r_id_pc     <= IF_PC;
            r_flush_cnt <= w_flush_inc;
        end else begin
            r_id_inst  <= IF_Inst;
            r_id_pc    <= IF_PC;
            r_id_valid <= 1'b1;
        end
    end

    assign ID_Inst     = r_id_inst;
    assign ID_PC       = r_id_pc;
    assign ID_Valid    = r_id_valid;
    assign Jump        = w_jump;
    assign ID_jpc      = {w_pc4_hi, w_f.target, 2'b00};
    assign stall       = w_stall;
    assign stall_count = r_stall_cnt;
    assign flush_count = r_flush_cnt;

endmodule

`default_nettype wire
